clk_div_prog: RTL

Runtime-programmable clock divider, the next generation of the fixed half-period divider. It generates a square-wave `clk_out`, one-cycle `rise`/`fall` strobes, and an enable/pause control, all from `clk_in`. The divisor is loadable at run time, so the timer front-end can switch between fast display-scan rates and the 1 Hz countdown rate without resynthesis. It sits between the board oscillator and the timer/display logic.

---
 rtl/clk_div_prog_if.sv | 35 +++
 rtl/clk_div_prog.sv | 133 +++++++++++++
 2 files changed

// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if
//   Control/status bundle for the programmable clock divider.
//   master: the controller that programs the divider (drives en, div_val,
//           div_load; observes the divided clock, strobes and status).
//   slave : the divider itself.
//
//   en            count enable; low pauses the divider
//   div_val       new half-period value (clk_in cycles)
//   div_load      one-cycle request to load div_val
//   clk_out       divided clock, 50% duty
//   rise / fall   one-cycle strobes in the cycle clk_out becomes 1 / 0
//   div_cur       active half-period
//   load_pending  a shadowed half-period is waiting to be applied
interface clk_div_prog_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic [WIDTH-1:0] div_val;
    logic             div_load;
    logic             clk_out;
    logic             rise;
    logic             fall;
    logic [WIDTH-1:0] div_cur;
    logic             load_pending;

    modport master (
        output en, div_val, div_load,
        input  clk_out, rise, fall, div_cur, load_pending
    );

    modport slave (
        input  en, div_val, div_load,
        output clk_out, rise, fall, div_cur, load_pending
    );
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog
//   Runtime-programmable half-period clock divider. Produces a 50% duty
//   clk_out whose half-period is div_cur enabled clk_in cycles, plus
//   registered one-cycle rise/fall strobes aligned with clk_out.
//
//   Optional feature macro: CLK_DIV_SHADOW_EN
//     undefined : div_load applies immediately (counter cleared, clk_out
//                 forced low, fall strobed if clk_out was high).
//     defined   : div_load writes a shadow register; the shadow is applied
//                 at the next fall so no runt pulse is ever produced.
//
//   Ports
//     clk_in  sole clock, rising edge
//     rst     synchronous active-high reset, overrides all other inputs
//     bus     clk_div_prog_if.slave (en, div_val, div_load in;
//             clk_out, rise, fall, div_cur, load_pending out)
module clk_div_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 100
) (
    input  logic           clk_in,
    input  logic           rst,
    clk_div_prog_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_cur_q;
    logic             clk_out_q;
    logic             rise_q;
    logic             fall_q;

    logic [WIDTH-1:0] div_clamped;
    logic             terminal;

    // A zero half-period is meaningless; it is treated as the fastest rate.
    assign div_clamped = (bus.div_val == '0) ? ONE : bus.div_val;

    // ">=" rather than "==" so a counter already past a newly shortened
    // half-period toggles on the next enabled edge instead of wrapping.
    assign terminal = bus.en && (cnt >= (div_cur_q - ONE));

`ifdef CLK_DIV_SHADOW_EN

    logic [WIDTH-1:0] shadow;
    logic             pending;
    logic             fall_now;

    // A fall on this edge marks the end of a full output period.
    assign fall_now = terminal && clk_out_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt       <= '0;
            clk_out_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            div_cur_q <= DIV_RST;
            shadow    <= '0;
            pending   <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;

            if (terminal) begin
                cnt       <= '0;
                clk_out_q <= ~clk_out_q;
                rise_q    <= ~clk_out_q;
                fall_q    <= clk_out_q;
            end else if (bus.en) begin
                cnt <= cnt + ONE;
            end

            // A load landing on the period boundary bypasses the shadow;
            // it takes precedence over any older pending value.
            if (bus.div_load && fall_now) begin
                div_cur_q <= div_clamped;
                pending   <= 1'b0;
            end else if (fall_now && pending) begin
                div_cur_q <= shadow;
                pending   <= 1'b0;
            end else if (bus.div_load) begin
                shadow  <= div_clamped;
                pending <= 1'b1;
            end
        end
    end

    assign bus.load_pending = pending;

`else

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt       <= '0;
            clk_out_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            div_cur_q <= DIV_RST;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;

            // Immediate reload restarts the output low; a high output is
            // cut short, so the strobe still reports the falling edge.
            if (bus.div_load) begin
                div_cur_q <= div_clamped;
                cnt       <= '0;
                clk_out_q <= 1'b0;
                fall_q    <= clk_out_q;
            end else if (terminal) begin
                cnt       <= '0;
                clk_out_q <= ~clk_out_q;
                rise_q    <= ~clk_out_q;
                fall_q    <= clk_out_q;
            end else if (bus.en) begin
                cnt <= cnt + ONE;
            end
        end
    end

    assign bus.load_pending = 1'b0;

`endif

    assign bus.clk_out = clk_out_q;
    assign bus.rise    = rise_q;
    assign bus.fall    = fall_q;
    assign bus.div_cur = div_cur_q;

endmodule
